m_spi_xfer_sequencer: RTL and testbench

//  Upstream feeder for m_spi_control. Buffers outgoing words in a TX FIFO and launches one SPI transfer
//  per word by pulsing start with o_data held stable. Collects each received word (i_data) into an
//  RX FIFO when is_sending falls. Exposes valid/ready streams to the user logic; flags stalled transfers.

---
 rtl/m_spi_xfer_sequencer.sv | 157 +++++++++++++++
 tb/tb_m_spi_xfer_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_spi_xfer_sequencer.sv
// m_spi_xfer_sequencer
//   Upstream feeder for m_spi_control. Outgoing words are buffered in a TX
//   FIFO. Each word is launched as one SPI transfer: start pulses for one
//   cycle, and o_data is held stable. When is_sending falls, the received
//   word (i_data) is collected into an RX FIFO. A transfer that stalls in
//   WAIT_BUSY or WAIT_DONE for TIMEOUT cycles is aborted and flagged.
//
// Ports
//   I_CLK, I_RESETN    clock, asynchronous active-low reset
//   s_valid/s_ready/s_data    TX stream from user logic (s_ready = TX not full)
//   m_valid/m_ready/m_data    RX stream to user logic (m_data = RX FIFO head)
//   start, o_data             launch pulse and word to m_spi_control
//   i_data, is_sending        received word and in-progress flag from m_spi_control
//   busy                      FSM not in IDLE
//   xfer_count                completed transfers (wraps)
//   err_timeout, err_clr      sticky timeout flag and its clear (set wins)
module m_spi_xfer_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_AW    = 2,
  parameter int TIMEOUT    = 4096,
  parameter int CNT_W      = 16
) (
  input  logic                  I_CLK,
  input  logic                  I_RESETN,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  start,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  is_sending,
  output logic                  busy,
  output logic [CNT_W-1:0]      xfer_count,
  output logic                  err_timeout,
  input  logic                  err_clr
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;

  logic [DATA_WIDTH-1:0] r_tx_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rx_mem [DEPTH];
  logic [FIFO_AW:0]      r_tx_wr, r_tx_rd, r_rx_wr, r_rx_rd;
  logic [1:0]            r_state;
  logic [TMR_W-1:0]      r_timer;

  logic w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
  logic w_tx_push, w_rx_push, w_rx_pop, w_launch, w_tmr_expired;

  // Pointers carry one extra wrap bit: equal means empty, MSB-only
  // difference means full.
  assign w_tx_empty = (r_tx_wr == r_tx_rd);
  assign w_tx_full  = (r_tx_wr[FIFO_AW] != r_tx_rd[FIFO_AW]) &&
                      (r_tx_wr[FIFO_AW-1:0] == r_tx_rd[FIFO_AW-1:0]);
  assign w_rx_empty = (r_rx_wr == r_rx_rd);
  assign w_rx_full  = (r_rx_wr[FIFO_AW] != r_rx_rd[FIFO_AW]) &&
                      (r_rx_wr[FIFO_AW-1:0] == r_rx_rd[FIFO_AW-1:0]);

  // s_ready depends only on registered occupancy. Therefore a pop by the FSM
  // in the same cycle does not open the slot until the following cycle.
  assign s_ready   = ~w_tx_full;
  assign m_valid   = ~w_rx_empty;
  assign m_data    = r_rx_mem[r_rx_rd[FIFO_AW-1:0]];

  assign w_tx_push = s_valid & ~w_tx_full;
  assign w_rx_pop  = ~w_rx_empty & m_ready;
  // Launching only with RX space reserves the slot for the response. Only one
  // transfer is ever in flight, so the RX push below can never overflow.
  assign w_launch  = (r_state == ST_IDLE) & ~w_tx_empty & ~w_rx_full;
  assign w_rx_push = (r_state == ST_WAIT_DONE) & ~is_sending;
  assign w_tmr_expired = (r_timer == TMR_LAST);

  always_ff @(posedge I_CLK) begin
    if (w_tx_push) r_tx_mem[r_tx_wr[FIFO_AW-1:0]] <= s_data;
    if (w_rx_push) r_rx_mem[r_rx_wr[FIFO_AW-1:0]] <= i_data;
  end

  always_ff @(posedge I_CLK or negedge I_RESETN) begin
    if (!I_RESETN) begin
      r_tx_wr <= '0;
      r_tx_rd <= '0;
      r_rx_wr <= '0;
      r_rx_rd <= '0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
      if (w_launch)  r_tx_rd <= r_tx_rd + 1'b1;
      if (w_rx_push) r_rx_wr <= r_rx_wr + 1'b1;
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + 1'b1;
    end
  end

  always_ff @(posedge I_CLK or negedge I_RESETN) begin
    if (!I_RESETN) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      start       <= 1'b0;
      o_data      <= '0;
      busy        <= 1'b0;
      xfer_count  <= '0;
      err_timeout <= 1'b0;
    end else begin
      start <= 1'b0;
      // The clear comes first, so a timeout in the same cycle overrides it.
      if (err_clr) err_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_launch) begin
            o_data  <= r_tx_mem[r_tx_rd[FIFO_AW-1:0]];
            start   <= 1'b1;
            busy    <= 1'b1;
            r_timer <= '0;
            r_state <= ST_WAIT_BUSY;
          end
        end
        ST_WAIT_BUSY: begin
          if (is_sending) begin
            r_timer <= '0;
            r_state <= ST_WAIT_DONE;
          end else if (w_tmr_expired) begin
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!is_sending) begin
            xfer_count <= xfer_count + 1'b1;
            busy       <= 1'b0;
            r_state    <= ST_IDLE;
          end else if (w_tmr_expired) begin
            // The aborted word is dropped: it is not pushed to RX and not retried.
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m_spi_xfer_sequencer.sv
// tb_m_spi_xfer_sequencer
//   Directed plus randomized bench for m_spi_xfer_sequencer. A loopback slave
//   model with random handshake delays returns each launched word unchanged.
//   Queues of accepted and returned words form the reference against which
//   launches, RX order, handshake readiness and counters are compared.
module tb_m_spi_xfer_sequencer;

  localparam int TMO = 16;

  logic        I_CLK = 1'b0;
  logic        I_RESETN;
  logic        s_valid, s_ready, m_valid, m_ready, start, is_sending, busy;
  logic        err_timeout, err_clr;
  logic [31:0] s_data, m_data, o_data, i_data;
  logic [15:0] xfer_count;

  m_spi_xfer_sequencer #(
    .DATA_WIDTH(32), .FIFO_AW(2), .TIMEOUT(TMO), .CNT_W(16)
  ) dut (
    .I_CLK(I_CLK), .I_RESETN(I_RESETN),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .start(start), .o_data(o_data), .i_data(i_data), .is_sending(is_sending),
    .busy(busy), .xfer_count(xfer_count),
    .err_timeout(err_timeout), .err_clr(err_clr)
  );

  always #5 I_CLK = ~I_CLK;

  int          compared, mismatched;
  logic [31:0] tx_q[$];    // accepted, not yet launched
  logic [31:0] rx_exp[$];  // returned by the slave, not yet consumed
  int          n_start, n_done, s_state, dly, len;
  logic [31:0] w_cap;
  logic        prev_start;
  bit          slave_en, rand_rdy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge I_CLK);
    #1;
    if (rand_rdy) m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic push(input logic [31:0] w);
    bit done = 0;
    s_valid = 1'b1;
    s_data  = w;
    for (int i = 0; i < 300 && !done; i++) begin
      if (s_ready) done = 1;
      tick();
    end
    s_valid = 1'b0;
    chk("push_accepted", done, 1);
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 0;
    for (int i = 0; i < 600 && !ok; i++) begin
      tick();
      ok = !busy && s_state == 0 && tx_q.size() == 0 && !is_sending;
    end
    chk(tag, ok, 1);
  endtask

  task automatic wait_drain(input string tag);
    bit ok = 0;
    for (int i = 0; i < 800 && !ok; i++) begin
      tick();
      ok = !busy && s_state == 0 && tx_q.size() == 0 && !is_sending &&
           rx_exp.size() == 0 && !m_valid;
    end
    chk(tag, ok, 1);
  endtask

  initial begin
    int base, base_cnt, n, n_acc;
    bit acc;
    compared = 0; mismatched = 0;
    I_RESETN = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    i_data = '0; is_sending = 1'b0; err_clr = 1'b0;
    slave_en = 1; rand_rdy = 0;
    n_start = 0; n_done = 0; s_state = 0; dly = 0; len = 0; w_cap = '0;
    prev_start = 1'b0;

    // Slave model (posedge + 2) and monitor/scoreboard (negedge) in one loop.
    fork
      begin : mon
        logic [31:0] expw;
        forever begin
          @(posedge I_CLK);
          #2;
          if (!I_RESETN) begin
            is_sending = 1'b0; s_state = 0; n_done = 0;
            tx_q.delete(); rx_exp.delete();
          end else begin
            if (start) chk("start_during_xfer", s_state, 0);
            case (s_state)
              0: if (start && slave_en) begin
                w_cap = o_data; dly = $urandom_range(0, 3); s_state = 1;
              end
              1: if (dly == 0) begin
                is_sending = 1'b1; len = $urandom_range(1, 6); s_state = 2;
              end else dly--;
              default: begin
                if (len == 0) begin
                  chk("o_data_hold", o_data, w_cap);
                  i_data = w_cap; is_sending = 1'b0;
                  rx_exp.push_back(w_cap); n_done++; s_state = 0;
                end else len--;
              end
            endcase
          end
          @(negedge I_CLK);
          if (I_RESETN) begin
            if (start) begin
              n_start++;
              chk("start_width", prev_start, 0);
              expw = (tx_q.size() > 0) ? tx_q.pop_front() : 'x;
              chk("launch_word", o_data, expw);
            end
            prev_start = start;
            chk("s_ready", s_ready, tx_q.size() < 4);
            chk("m_valid_backed", m_valid && (rx_exp.size() == 0), 0);
            if (m_valid && m_ready) begin
              expw = (rx_exp.size() > 0) ? rx_exp.pop_front() : 'x;
              chk("m_data", m_data, expw);
            end
            if (s_valid && s_ready) tx_q.push_back(s_data);
          end else prev_start = 1'b0;
        end
      end
    join_none

    // Reset state
    tick(); tick();
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_o_data", o_data, 0);
    chk("rst_count", xfer_count, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_m_valid", m_valid, 0);
    I_RESETN = 1'b1;
    tick();
    chk("rst_s_ready", s_ready, 1);

    // Single transfer, held in RX for inspection
    push(32'hA5A50001);
    wait_idle("single_idle");
    chk("single_m_valid", m_valid, 1);
    chk("single_m_data", m_data, 32'hA5A50001);
    chk("single_count", xfer_count, 1);
    chk("single_busy", busy, 0);
    m_ready = 1'b1;
    tick();

    // Burst of four
    base = n_start;
    push(32'h1); push(32'h2); push(32'h3); push(32'h4);
    wait_drain("burst_drain");
    chk("burst_starts", n_start - base, 4);
    chk("burst_count", xfer_count, n_done[15:0]);

    // Backpressure: RX and TX fill, nothing further launches
    m_ready = 1'b0;
    base = n_start; n_acc = 0;
    s_valid = 1'b1; s_data = $urandom;
    for (int i = 0; i < 80; i++) begin
      acc = s_ready;
      tick();
      if (acc) begin
        n_acc++;
        if (n_acc == 10) s_valid = 1'b0;
        s_data = $urandom;
      end
    end
    chk("bp_accepted", n_acc, 8);
    chk("bp_starts", n_start - base, 4);
    chk("bp_s_ready", s_ready, 0);
    chk("bp_m_valid", m_valid, 1);
    chk("bp_busy", busy, 0);
    // One pop frees one RX slot. The FSM pops TX while s_valid is pending on a
    // full TX FIFO, so that word enters one cycle later.
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("edge_s_ready_hold", s_ready, 0);
    chk("edge_no_start_yet", start, 0);
    tick();
    chk("edge_start", start, 1);
    chk("edge_s_ready_open", s_ready, 1);
    tick();
    s_valid = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    chk("bp_one_more", n_start - base, 5);
    chk("bp_refull", s_ready, 0);
    m_ready = 1'b1;
    wait_drain("bp_drain");
    chk("bp_count", xfer_count, n_done[15:0]);

    // Timeout: slave never answers
    slave_en = 0; base_cnt = n_done;
    push(32'hDEAD);
    n = 0;
    while (!start && n < 10) begin tick(); n++; end
    chk("to_launch", start, 1);
    n = 0;
    while (!err_timeout && n < 4 * TMO) begin tick(); n++; end
    chk("to_latency", (n >= TMO) && (n <= TMO + 1), 1);
    chk("to_busy", busy, 0);
    chk("to_m_valid", m_valid, 0);
    chk("to_count", xfer_count, n_done[15:0]);
    slave_en = 1;
    push(32'h1234);
    wait_drain("to_next_drain");
    chk("to_next_count", xfer_count, 16'(base_cnt + 1));
    chk("to_sticky", err_timeout, 1);
    err_clr = 1'b1;
    tick();
    chk("to_clear", err_timeout, 0);
    // err_clr held across a second timeout: the set wins
    slave_en = 0;
    push(32'hBEEF);
    n = 0;
    while (!start && n < 10) begin tick(); n++; end
    n = 0;
    while (busy && n < 4 * TMO) begin tick(); n++; end
    chk("setwins_err", err_timeout, 1);
    tick();
    chk("setwins_clear", err_timeout, 0);
    err_clr = 1'b0;
    slave_en = 1;
    wait_drain("to_drain");

    // Reset mid-transfer with words buffered
    for (int i = 0; i < 4; i++) push($urandom);
    n = 0;
    while (!is_sending && n < 20) begin tick(); n++; end
    chk("mid_in_done", is_sending && busy, 1);
    I_RESETN = 1'b0;
    #1;
    chk("mid_rst_start", start, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_s_ready", s_ready, 1);
    chk("mid_rst_count", xfer_count, 0);
    chk("mid_rst_o_data", o_data, 0);
    tick(); tick();
    I_RESETN = 1'b1;
    base = n_start;
    for (int i = 0; i < 10; i++) tick();
    chk("mid_no_start", n_start - base, 0);
    chk("mid_s_ready", s_ready, 1);
    chk("mid_busy", busy, 0);
    chk("mid_m_valid", m_valid, 0);

    // Randomized traffic with random consumer readiness
    rand_rdy = 1;
    for (int i = 0; i < 24; i++) begin
      push($urandom);
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end
    rand_rdy = 0;
    m_ready = 1'b1;
    wait_drain("rand_drain");
    chk("rand_count", xfer_count, n_done[15:0]);
    chk("rand_err", err_timeout, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
